// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder:
// group generate/propagate, flattened lookahead carries and a
// parameter sanity check used at elaboration.
package cla_pkg;

    localparam int MAX_GROUP  = 16;
    localparam int MAX_GROUPS = 64;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Group generate/propagate over the low n bits of a/b.
    function automatic gp_t group_gp(input logic [MAX_GROUP-1:0] a,
                                     input logic [MAX_GROUP-1:0] b,
                                     input int n);
        gp_t r;
        r.g = 1'b0;
        r.p = 1'b1;
        for (int i = 0; i < MAX_GROUP; i++) begin
            if (i < n) begin
                r.g = (a[i] & b[i]) | ((a[i] ^ b[i]) & r.g);
                r.p = r.p & (a[i] ^ b[i]);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Carries c[0..n] in sum-of-products form: each carry is an OR of
    // generate terms gated by the propagates above them, so no carry
    // ripples through the previous one.
    function automatic logic [MAX_GROUPS:0] lookahead(input gp_t [MAX_GROUPS-1:0] gp,
                                                      input int n,
                                                      input logic cin);
        logic [MAX_GROUPS:0] c;
        logic acc;
        logic run_p;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < MAX_GROUPS; i++) begin
            if (i < n) begin
                acc   = 1'b0;
                run_p = 1'b1;
                for (int j = i; j >= 0; j--) begin
                    acc   = acc | (run_p & gp[j].g);
                    run_p = run_p & gp[j].p;
                end
                c[i+1] = acc | (run_p & cin);
            end else begin
                c[i+1] = 1'b0;
            end
        end
        return c;
    endfunction

    // True when the width splits evenly into stages of whole groups.
    function automatic bit cfg_ok(input int width, input int stages, input int group);
        return (stages > 0) && (group > 0) && (group <= MAX_GROUP) &&
               ((width % (stages * group)) == 0) &&
               ((width / (stages * group)) <= MAX_GROUPS);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead slice: group G/P, lookahead across
// groups, and parallel bit carries inside each group.
module cla_slice
    import cla_pkg::*;
#(
    parameter int SW    = 16,
    parameter int GROUP = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    localparam int NG = SW / GROUP;

    gp_t [MAX_GROUPS-1:0] grp_s;
    logic [MAX_GROUPS:0]  gcarry_s;

    // Generate/propagate for each group of GROUP bits.
    always_comb begin
        grp_s = '0;
        for (int g = 0; g < NG; g++) begin
            grp_s[g] = group_gp(MAX_GROUP'(a[g*GROUP +: GROUP]),
                                MAX_GROUP'(b[g*GROUP +: GROUP]), GROUP);
        end
    end

    assign gcarry_s = lookahead(grp_s, NG, cin);
    assign cout     = gcarry_s[NG];

    // Bit carries inside each group from that group's lookahead carry-in.
    always_comb begin
        gp_t [MAX_GROUPS-1:0] bit_gp;
        logic [MAX_GROUPS:0]  bit_c;
        sum    = '0;
        bit_gp = '0;
        bit_c  = '0;
        for (int g = 0; g < NG; g++) begin
            bit_gp = '0;
            for (int i = 0; i < GROUP; i++) begin
                bit_gp[i].g = a[g*GROUP+i] & b[g*GROUP+i];
                bit_gp[i].p = a[g*GROUP+i] ^ b[g*GROUP+i];
            end
            bit_c = lookahead(bit_gp, GROUP, gcarry_s[g]);
            for (int i = 0; i < GROUP; i++) begin
                sum[g*GROUP+i] = bit_gp[i].p ^ bit_c[i];
            end
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both
// sides. Stage s adds slice s; upper operand slices travel with the beat.
// Define CLA_FLAGS_EN to add the registered Overflow and Zero outputs.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             Overflow,
    output logic             Zero
`endif
);

    localparam int  SW     = WIDTH / STAGES;
    localparam int  LAST   = STAGES - 1;
    localparam bit  CFG_OK = cfg_ok(WIDTH, STAGES, GROUP);

    if (!CFG_OK) begin : g_cfg_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*GROUP");
    end

    logic [STAGES-1:0] valid_r;
    logic [WIDTH-1:0]  a_r       [STAGES];
    logic [WIDTH-1:0]  b_r       [STAGES];
    logic [WIDTH-1:0]  sum_r     [STAGES];
    logic [STAGES-1:0] carry_r;

    logic [STAGES-1:0] ready_s;
    logic [WIDTH-1:0]  a_in_s     [STAGES];
    logic [WIDTH-1:0]  b_in_s     [STAGES];
    logic [WIDTH-1:0]  sum_in_s   [STAGES];
    logic [WIDTH-1:0]  sum_next_s [STAGES];
    logic [SW-1:0]     slice_sum_s[STAGES];
    logic [STAGES-1:0] carry_in_s;
    logic [STAGES-1:0] valid_in_s;
    logic [STAGES-1:0] slice_cout_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_in_s[k]     = A;
            assign b_in_s[k]     = B ^ {WIDTH{Sub}};
            assign carry_in_s[k] = Cin ^ Sub;
            assign sum_in_s[k]   = '0;
            assign valid_in_s[k] = in_valid;
        end else begin : g_next
            assign a_in_s[k]     = a_r[k-1];
            assign b_in_s[k]     = b_r[k-1];
            assign carry_in_s[k] = carry_r[k-1];
            assign sum_in_s[k]   = sum_r[k-1];
            assign valid_in_s[k] = valid_r[k-1];
        end

        cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
            .a    (a_in_s[k][k*SW +: SW]),
            .b    (b_in_s[k][k*SW +: SW]),
            .cin  (carry_in_s[k]),
            .sum  (slice_sum_s[k]),
            .cout (slice_cout_s[k])
        );
    end

    // Merge each stage's new slice into the partial sum it inherits.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_next_s[k]              = sum_in_s[k];
            sum_next_s[k][k*SW +: SW]  = slice_sum_s[k];
        end
    end

    // A stage can load unless it and every stage after it are full and the consumer stalls.
    always_comb begin
        logic all_full;
        ready_s  = '0;
        all_full = 1'b1;
        for (int k = LAST; k >= 0; k--) begin
            all_full   = all_full & valid_r[k];
            ready_s[k] = out_ready | ~all_full;
        end
    end

    // Stage registers: advance when ready, hold data and valid while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= 1'b0;
                a_r[k]     <= '0;
                b_r[k]     <= '0;
                sum_r[k]   <= '0;
                carry_r[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready_s[k]) begin
                    valid_r[k] <= valid_in_s[k];
                    if (valid_in_s[k]) begin
                        a_r[k]     <= a_in_s[k];
                        b_r[k]     <= b_in_s[k];
                        sum_r[k]   <= sum_next_s[k];
                        carry_r[k] <= slice_cout_s[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ready_s[0];
    assign out_valid = valid_r[LAST];
    assign Sum       = sum_r[LAST];
    assign Cout      = carry_r[LAST];

`ifdef CLA_FLAGS_EN
    logic ovf_r;
    logic zero_r;

    // Flags captured together with the final stage so they share its timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (ready_s[LAST] && valid_in_s[LAST]) begin
            ovf_r  <= (a_in_s[LAST][WIDTH-1] == b_in_s[LAST][WIDTH-1]) &&
                      (sum_next_s[LAST][WIDTH-1] != a_in_s[LAST][WIDTH-1]);
            zero_r <= ~|sum_next_s[LAST];
        end
    end

    assign Overflow = ovf_r;
    assign Zero     = zero_r;
`endif

endmodule
